mux_32to1: RTL and testbench

- 32-input, 64-bit-wide selector for the datapath, e.g. register-file read port and operand selection.
- Combinational output `out = in[sel]` with zero latency.
- Also provides a registered copy `out_q` for pipeline-stage use.
- Built hierarchically:
  - five 4:1 muxes form one 16:1 mux;
  - two 16:1 muxes plus a final 2:1 stage form the 32:1 mux.

---
 rtl/mux_32to1.sv | 104 ++++++++++
 tb/tb_mux_32to1.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mux_32to1.sv
// 32:1 datapath selector built from 4:1 / 16:1 / 2:1 sub-muxes.
// Provides a combinational result and a registered copy for pipeline use.

module mux_4to1 #(
    parameter int WIDTH = 64
) (
    input  logic [3:0][WIDTH-1:0] d,
    input  logic [1:0]            s,
    output logic [WIDTH-1:0]      y
);
    always_comb begin
        y = d[0];
        case (s)
            2'd0: y = d[0];
            2'd1: y = d[1];
            2'd2: y = d[2];
            2'd3: y = d[3];
            default: y = d[0];
        endcase
    end
endmodule

module mux_2to1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

module mux_16to1 #(
    parameter int WIDTH = 64
) (
    input  logic [15:0][WIDTH-1:0] d,
    input  logic [3:0]             s,
    output logic [WIDTH-1:0]       y
);
    logic [3:0][WIDTH-1:0] grp_y;

    // First level picks within each group of four on s[1:0], second level picks the group.
    for (genvar g = 0; g < 4; g++) begin : g_lvl0
        mux_4to1 #(.WIDTH(WIDTH)) u_mux (
            .d (d[g*4 +: 4]),
            .s (s[1:0]),
            .y (grp_y[g])
        );
    end

    mux_4to1 #(.WIDTH(WIDTH)) u_lvl1 (
        .d (grp_y),
        .s (s[3:2]),
        .y (y)
    );
endmodule

module mux_32to1 #(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             sel,
    input  logic [31:0][WIDTH-1:0] in,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH-1:0]       out_q
);
    logic [WIDTH-1:0] lo_y;
    logic [WIDTH-1:0] hi_y;
    logic [WIDTH-1:0] out_d;

    mux_16to1 #(.WIDTH(WIDTH)) u_lo (
        .d (in[15:0]),
        .s (sel[3:0]),
        .y (lo_y)
    );

    mux_16to1 #(.WIDTH(WIDTH)) u_hi (
        .d (in[31:16]),
        .s (sel[3:0]),
        .y (hi_y)
    );

    mux_2to1 #(.WIDTH(WIDTH)) u_top (
        .d0 (lo_y),
        .d1 (hi_y),
        .s  (sel[4]),
        .y  (out)
    );

    always_comb begin
        out_d = out;
    end

    // Reset clears only the pipeline copy; the combinational path stays live.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_mux_32to1.sv
// Self-checking bench for mux_32to1: directed patterns, reset, simultaneous change, random phase.
`timescale 1ns/1ps

module tb_mux_32to1;
    localparam int W = 64;

    logic                clk;
    logic                reset;
    logic [4:0]          sel;
    logic [31:0][W-1:0]  in_bus;
    logic [W-1:0]        out;
    logic [W-1:0]        out_q;

    logic [W-1:0] mdl [32];
    int checks;
    int failures;

    mux_32to1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .in    (in_bus),
        .out   (out),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_model();
        for (int i = 0; i < 32; i++) in_bus[i] = mdl[i];
    endtask

    // Each step: drive at negedge, check comb output, then check the register after the edge.
    task automatic sweep(input string tag);
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            sel = 5'(s);
            drive_model();
            #1;
            chk({tag, "_out"}, out, mdl[s]);
            @(posedge clk);
            #1;
            chk({tag, "_out_q"}, out_q, mdl[s]);
        end
    endtask

    initial begin
        logic [W-1:0] exp_q;
        logic         rst_r;
        int           s_r;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        sel      = '0;
        in_bus   = '0;
        for (int i = 0; i < 32; i++) mdl[i] = W'(64'd7 + 64'(i));
        drive_model();
        @(posedge clk);
        #1;
        chk("reset_state_out_q", out_q, '0);
        chk("reset_state_out", out, mdl[0]);
        @(negedge clk);
        reset = 1'b0;

        // Identity
        for (int i = 0; i < 32; i++) mdl[i] = W'(i);
        sweep("identity");

        // Half split
        for (int i = 0; i < 32; i++) mdl[i] = (i > 15) ? W'(1) : W'(0);
        sweep("half");

        // Modulo 3
        for (int i = 0; i < 32; i++) mdl[i] = (i % 3 == 1) ? W'(1) : W'(0);
        sweep("mod3");

        // Full width
        for (int i = 0; i < 32; i++)
            mdl[i] = (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0001;
        sweep("fullw");

        // Reset with held inputs
        for (int i = 0; i < 32; i++) mdl[i] = 64'h1111_0000_0000_0000 | W'(i);
        mdl[5] = 64'hA5;
        @(negedge clk);
        sel = 5'd5;
        drive_model();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("rst_out_q", out_q, '0);
            chk("rst_out", out, 64'hA5);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_out_q_hold", out_q, '0);
        @(posedge clk);
        #1;
        chk("rst_release_out_q", out_q, 64'hA5);

        // Simultaneous change of sel and in[28]
        @(negedge clk);
        mdl[28] = '0;
        sel = 5'd3;
        drive_model();
        @(posedge clk);
        #1;
        chk("simul_pre_out_q", out_q, mdl[3]);
        @(negedge clk);
        mdl[28] = 64'h1234;
        sel = 5'd28;
        drive_model();
        #1;
        chk("simul_out", out, 64'h1234);
        @(posedge clk);
        #1;
        chk("simul_out_q", out_q, 64'h1234);

        // Random phase with occasional reset
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            for (int i = 0; i < 32; i++) mdl[i] = {$urandom(), $urandom()};
            s_r   = int'($urandom_range(31, 0));
            rst_r = ($urandom_range(9, 0) == 0);
            sel   = 5'(s_r);
            reset = rst_r;
            drive_model();
            exp_q = rst_r ? '0 : mdl[s_r];
            #1;
            chk("rand_out", out, mdl[s_r]);
            @(posedge clk);
            #1;
            chk("rand_out_q", out_q, exp_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
